// File: rtl/fft_pkg.sv
// Shared definitions for the FFT pipeline blocks (frame sequencer, fft core, fft_spi_out).
// Holds the frame-sequencer state encoding, the default FFT geometry and an address-width
// helper so every block sizes its sample address the same way.
package fft_pkg;

  // Encodings are fixed so they stay stable if ever exported on a debug bus.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StCompute = 2'd2,
    StOutput  = 2'd3
  } fft_state_e;

  localparam int unsigned FftN       = 16;
  localparam int unsigned FftDw      = 16;
  localparam int unsigned FftTimeout = 65535;

  // Width of a sample address for an n-point FFT; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_watchdog.sv
// Loadable up-counter with synchronous clear, count enable and expiry flag.
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   clear_i     force the count to zero (highest priority)
//   load_i      load load_val_i into the count
//   load_val_i  value for load_i
//   en_i        count one per cycle while high
//   expired_o   high in the cycle whose increment would make the count reach TIMEOUT
module fft_watchdog #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         load_i,
  input  logic [$clog2(TIMEOUT+1)-1:0] load_val_i,
  input  logic                         en_i,
  output logic                         expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;
  logic            at_last;

  // Flagging one count early lets a registered consumer react on exactly the
  // TIMEOUT-th enabled cycle.
  assign at_last   = (cnt_q == CntW'(TIMEOUT - 1));
  assign expired_o = en_i && at_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && !at_last) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the FFT pipeline. Collects N ADC samples and writes them into the
// fft core, waits for fft_finish, kicks fft_spi_out and waits for its transfer to drain.
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               begin a frame (IDLE only)
//   continuous_i          auto-restart after each frame, sampled at end of OUTPUT
//   sample_valid_i/data_i ADC sample stream
//   insert_data_o/addr_o/data_out_o  write port into the fft core
//   fft_finish_i          fft done pulse
//   spi_start_o/spi_busy_i  handshake with fft_spi_out
//   busy_o, frame_count_o, overrun_o, timeout_err_o  status
// All outputs are registered.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned N       = FftN,
  parameter int unsigned DW      = FftDw,
  parameter int unsigned TIMEOUT = FftTimeout
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 continuous_i,
  input  logic                 sample_valid_i,
  input  logic [DW-1:0]        sample_data_i,
  output logic                 insert_data_o,
  output logic [addr_w(N)-1:0] addr_o,
  output logic [DW-1:0]        data_out_o,
  input  logic                 fft_finish_i,
  output logic                 spi_start_o,
  input  logic                 spi_busy_i,
  output logic                 busy_o,
  output logic [15:0]          frame_count_o,
  output logic                 overrun_o,
  output logic                 timeout_err_o
);

  localparam int unsigned AddrW = addr_w(N);
  localparam int unsigned CntW  = $clog2(TIMEOUT + 1);

  fft_state_e       state_q;
  logic [AddrW-1:0] idx_q;
  logic [AddrW-1:0] addr_q;
  logic [DW-1:0]    data_out_q;
  logic             insert_q;
  logic             spi_start_q;
  logic             busy_q;
  logic [15:0]      frame_count_q;
  logic             overrun_q;
  logic             timeout_err_q;
  logic             seen_busy_q;

  logic wd_en;
  logic wd_clear;
  logic wd_expired;

  // Counter runs only in COMPUTE/OUTPUT; holding it clear elsewhere and on the
  // COMPUTE->OUTPUT edge makes it read zero on the first cycle of either state.
  always_comb begin
    wd_en    = (state_q == StCompute) || (state_q == StOutput);
    wd_clear = !wd_en || ((state_q == StCompute) && fft_finish_i);
  end

  fft_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (wd_clear),
    .load_i    (1'b0),
    .load_val_i({CntW{1'b0}}),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      addr_q        <= '0;
      data_out_q    <= '0;
      insert_q      <= 1'b0;
      spi_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      seen_busy_q   <= 1'b0;
    end else begin
      insert_q    <= 1'b0;
      spi_start_q <= 1'b0;

      // A sample outside LOAD is dropped; only a streaming capture treats it as a gap.
      // Placed before the case so a start in IDLE clears it on the same edge.
      if (sample_valid_i && (state_q != StLoad) && continuous_i) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q       <= StLoad;
            busy_q        <= 1'b1;
            idx_q         <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
          end
        end

        StLoad: begin
          if (sample_valid_i) begin
            data_out_q <= sample_data_i;
            addr_q     <= idx_q;
            insert_q   <= 1'b1;
            idx_q      <= idx_q + AddrW'(1);
            if (idx_q == AddrW'(N - 1)) begin
              state_q <= StCompute;
            end
          end
        end

        StCompute: begin
          if (wd_expired) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
          end else if (fft_finish_i) begin
            state_q     <= StOutput;
            spi_start_q <= 1'b1;
            seen_busy_q <= 1'b0;
          end
        end

        StOutput: begin
          if (wd_expired) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
          end else if (spi_busy_i) begin
            seen_busy_q <= 1'b1;
          end else if (seen_busy_q) begin
            // Transfer drained: frame complete.
            frame_count_q <= frame_count_q + 16'd1;
            if (continuous_i) begin
              state_q <= StLoad;
              idx_q   <= '0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign insert_data_o = insert_q;
  assign addr_o        = addr_q;
  assign data_out_o    = data_out_q;
  assign spi_start_o   = spi_start_q;
  assign busy_o        = busy_q;
  assign frame_count_o = frame_count_q;
  assign overrun_o     = overrun_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl. Two instances share all inputs: u_dut uses the
// default watchdog limit, u_dut_wd uses TIMEOUT=100 for the watchdog scenario.
module tb_fft_frame_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic          continuous;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          fft_finish;
  logic          spi_busy;

  logic          insert_data;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          spi_start;
  logic          busy;
  logic [15:0]   frame_count;
  logic          overrun;
  logic          timeout_err;

  logic          w_insert_data;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data_out;
  logic          w_spi_start;
  logic          w_busy;
  logic [15:0]   w_frame_count;
  logic          w_overrun;
  logic          w_timeout_err;

  int n_checks   = 0;
  int n_fails    = 0;
  int spi_pulses = 0;
  int exp_frames = 0;
  int p0;

  fft_frame_ctrl #(
    .N      (N),
    .DW     (DW),
    .TIMEOUT(65535)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .continuous_i  (continuous),
    .sample_valid_i(sample_valid),
    .sample_data_i (sample_data),
    .insert_data_o (insert_data),
    .addr_o        (addr),
    .data_out_o    (data_out),
    .fft_finish_i  (fft_finish),
    .spi_start_o   (spi_start),
    .spi_busy_i    (spi_busy),
    .busy_o        (busy),
    .frame_count_o (frame_count),
    .overrun_o     (overrun),
    .timeout_err_o (timeout_err)
  );

  fft_frame_ctrl #(
    .N      (N),
    .DW     (DW),
    .TIMEOUT(100)
  ) u_dut_wd (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .continuous_i  (continuous),
    .sample_valid_i(sample_valid),
    .sample_data_i (sample_data),
    .insert_data_o (w_insert_data),
    .addr_o        (w_addr),
    .data_out_o    (w_data_out),
    .fft_finish_i  (fft_finish),
    .spi_start_o   (w_spi_start),
    .spi_busy_i    (spi_busy),
    .busy_o        (w_busy),
    .frame_count_o (w_frame_count),
    .overrun_o     (w_overrun),
    .timeout_err_o (w_timeout_err)
  );

  always @(negedge clk) begin
    if (spi_start) spi_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_insert"}, 32'(insert_data), 0);
    check_eq({pfx, "_addr"}, 32'(addr), 0);
    check_eq({pfx, "_data"}, 32'(data_out), 0);
    check_eq({pfx, "_spi_start"}, 32'(spi_start), 0);
    check_eq({pfx, "_busy"}, 32'(busy), 0);
    check_eq({pfx, "_frame_count"}, 32'(frame_count), 0);
    check_eq({pfx, "_overrun"}, 32'(overrun), 0);
    check_eq({pfx, "_timeout"}, 32'(timeout_err), 0);
  endtask

  // Feed n samples with 'gap' idle cycles after each; optionally raise fft_finish with
  // the last sample and pulse start during the gap after sample 5 (both must be ignored).
  task automatic load_frame(input int n, input int gap, input logic [15:0] base,
                            input bit finish_on_last, input bit poke_start);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data  = base + 16'(i);
      fft_finish   = finish_on_last && (i == n - 1);
      tick();
      sample_valid = 1'b0;
      fft_finish   = 1'b0;
      check_eq($sformatf("ld_strobe[%0d]", i), 32'(insert_data), 1);
      check_eq($sformatf("ld_addr[%0d]", i), 32'(addr), 32'(i));
      check_eq($sformatf("ld_data[%0d]", i), 32'(data_out), 32'(base + 16'(i)));
      for (int g = 0; g < gap; g++) begin
        start = poke_start && (i == 5) && (g == 0);
        tick();
        start = 1'b0;
        check_eq($sformatf("ld_gap[%0d.%0d]", i, g), 32'(insert_data), 0);
      end
    end
  endtask

  // From COMPUTE: fft_finish after 'delay' cycles, then spi_busy high for busy_len cycles.
  task automatic finish_frame(input int delay, input int busy_len);
    repeat (delay - 1) tick();
    check_eq("cmp_no_strobe", 32'(insert_data), 0);
    check_eq("cmp_busy", 32'(busy), 1);
    check_eq("cmp_no_spi_start", 32'(spi_start), 0);
    fft_finish = 1'b1;
    tick();
    fft_finish = 1'b0;
    check_eq("spi_start_entry", 32'(spi_start), 1);
    spi_busy = 1'b1;
    repeat (busy_len) tick();
    check_eq("spi_start_single", 32'(spi_start), 0);
    check_eq("fc_hold_while_busy", 32'(frame_count), 32'(exp_frames));
    spi_busy = 1'b0;
    tick();
    exp_frames++;
    check_eq("fc_after_busy_fall", 32'(frame_count), 32'(exp_frames));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    continuous   = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    fft_finish   = 1'b0;
    spi_busy     = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_reset("rst");

    // Back-to-back load; fft_finish coinciding with the last sample is dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t1_busy_load", 32'(busy), 1);
    check_eq("t1_no_strobe_yet", 32'(insert_data), 0);
    p0 = spi_pulses;
    load_frame(16, 0, 16'h0100, 1'b1, 1'b0);
    tick();
    check_eq("t1_compute_busy", 32'(busy), 1);
    check_eq("t1_compute_no_strobe", 32'(insert_data), 0);
    check_eq("t1_early_finish_ignored", 32'(spi_start), 0);

    // Compute/output handshake, non-continuous
    finish_frame(39, 256);
    check_eq("t3_spi_pulses", 32'(spi_pulses - p0), 1);
    check_eq("t3_idle", 32'(busy), 0);
    tick();
    check_eq("t3_stays_idle", 32'(busy), 0);

    // Sparse samples, start pulse mid-load ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    load_frame(16, 2, 16'h0200, 1'b0, 1'b1);
    finish_frame(5, 3);
    check_eq("t2_idle", 32'(busy), 0);

    // Continuous: three frames, one stray sample during COMPUTE of the first
    continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_frame(16, 0, 16'h0300, 1'b0, 1'b0);
    sample_valid = 1'b1;
    sample_data  = 16'hdead;
    tick();
    sample_valid = 1'b0;
    check_eq("t4_overrun_set", 32'(overrun), 1);
    check_eq("t4_stray_dropped", 32'(insert_data), 0);
    finish_frame(10, 4);
    check_eq("t4_restart1", 32'(busy), 1);
    load_frame(16, 0, 16'h0400, 1'b0, 1'b0);
    finish_frame(10, 4);
    check_eq("t4_restart2", 32'(busy), 1);
    load_frame(16, 0, 16'h0500, 1'b0, 1'b0);
    continuous = 1'b0;
    finish_frame(10, 4);
    check_eq("t4_idle_after_drop", 32'(busy), 0);
    check_eq("t4_frames", 32'(frame_count), 5);
    check_eq("t4_overrun_sticky", 32'(overrun), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t4_overrun_cleared", 32'(overrun), 0);
    check_eq("t4_new_frame_busy", 32'(busy), 1);

    // Watchdog with TIMEOUT=100, fft_finish withheld
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_wd_reset_busy", 32'(w_busy), 0);
    check_eq("t5_wd_reset_timeout", 32'(w_timeout_err), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_frame(16, 0, 16'h0600, 1'b0, 1'b0);
    check_eq("t5_wd_last_strobe", 32'(w_addr), 15);
    repeat (99) tick();
    check_eq("t5_wd_not_yet", 32'(w_timeout_err), 0);
    check_eq("t5_wd_still_busy", 32'(w_busy), 1);
    tick();
    check_eq("t5_wd_timeout", 32'(w_timeout_err), 1);
    check_eq("t5_wd_idle", 32'(w_busy), 0);
    check_eq("t5_wd_frames", 32'(w_frame_count), 0);
    check_eq("t5_main_no_timeout", 32'(timeout_err), 0);
    check_eq("t5_main_busy", 32'(busy), 1);

    // Reset mid-load, then a fresh frame starts at address 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_frame(7, 0, 16'h0700, 1'b0, 1'b0);
    rst          = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 16'h0707;
    tick();
    rst          = 1'b0;
    sample_valid = 1'b0;
    check_reset("t6");
    start = 1'b1;
    tick();
    start = 1'b0;
    sample_valid = 1'b1;
    sample_data  = 16'hbeef;
    tick();
    sample_valid = 1'b0;
    check_eq("t6_strobe", 32'(insert_data), 1);
    check_eq("t6_addr0", 32'(addr), 0);
    check_eq("t6_data", 32'(data_out), 32'h0000beef);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
